dtc_ctrl: RTL
=============

DTC_CTRL -- requirements
Module: dtc_ctrl

Interface
REQ-001 SHALL have parameter INIT_PHASE, default 16'h0000, accumulator value loaded on PRIME entry.
REQ-002 SHALL have parameter LMS_STEP, default 1, KDTC_EST update magnitude in LSBs (used only with DTC_LMS_EN).
REQ-003 SHALL have port CKR, input, 1, reference clock; all logic on its rising edge.
REQ-004 SHALL have port RST, input, 1, reset; the reset is synchronous and active-high.
REQ-005 SHALL have port EN, input, 1, run enable.
REQ-006 SHALL have port FCW_FRAC, input, 16, fractional frequency control word in units of 2^-16 CKV period.
REQ-007 SHALL have port KDTC, input, 12, DTC gain in DTC LSBs per full CKV period, unsigned.
REQ-008 SHALL have port PHE_SGN, input, 1, sign of the measured phase error (1 = late).
REQ-009 SHALL have port DTCDCW, output, 12, DTC control word, unsigned.
REQ-010 SHALL have port CARRY, output, 1, accumulator overflow flag aligned with DTCDCW; tells the divider to swallow one CKV period.
REQ-011 SHALL have port VLD, output, 1, DTCDCW/CARRY valid.
REQ-012 SHALL have port KDTC_EST, output, 12, gain actually applied.

Function
REQ-013 SHALL implement FSM states IDLE, PRIME and RUN.
REQ-014 SHALL transition IDLE->PRIME when EN=1, PRIME->RUN unconditionally, and any state->IDLE when EN=0.
REQ-015 SHALL, in IDLE, hold the accumulator at 0 and drive DTCDCW=0, CARRY=0 and VLD=0.
REQ-016 SHALL, on PRIME entry, load the accumulator with INIT_PHASE and load the gain register from KDTC.
REQ-017 SHALL, in RUN, update the accumulator as ACC <= ACC + FCW_FRAC modulo 2^16 every cycle, with carry-out C captured into stage 1 alongside the new ACC.
REQ-018 SHALL form stage 2 as DTCDCW <= bits [27:16] of (ACC_stage1 * gain), with 16x12 unsigned multiply and truncation; no saturation is required because the result is at most 4095.
REQ-019 SHALL make CARRY the stage-1 carry registered in the same cycle as the DTCDCW it accompanies.
REQ-020 SHALL keep latency from an FCW_FRAC sample to the DTCDCW reflecting it at exactly 2 CKR cycles.
REQ-021 SHALL assert VLD from the 2nd RUN cycle onward; VLD SHALL drop in the same cycle the FSM enters IDLE.
REQ-022 SHALL take an FCW_FRAC change in RUN into account in the next accumulation, without a pipeline flush.
REQ-023 SHALL, when the accumulator wraps to exactly 0, output DTCDCW=0 and CARRY=1.
REQ-024 SHALL, for FCW_FRAC=0, hold the accumulator constant with CARRY never asserted.
REQ-025 SHALL, when EN drops and rises again on the next cycle, pass through PRIME and reload INIT_PHASE with no stale VLD.

Reset
REQ-026 SHALL, with RST=1 at a CKR edge, set the FSM to IDLE, clear the accumulator and pipeline, and drive DTCDCW=0, CARRY=0, VLD=0 and KDTC_EST=KDTC.
REQ-027 SHALL let RST override EN; reset asserted mid-RUN SHALL give an IDLE-state output one cycle later.
REQ-028 SHALL, after RST deasserts with EN=1, enter PRIME on the first edge.

Configuration
REQ-029 SHALL, with DTC_LMS_EN defined, update the gain register every RUN cycle where VLD=1 and ACC_stage1[15]=1: +LMS_STEP if PHE_SGN=1, else -LMS_STEP, saturating to 0..4095.
REQ-030 SHALL, with DTC_LMS_EN defined, drive KDTC_EST with the gain register and use it in the multiply.
REQ-031 SHALL, without DTC_LMS_EN, use KDTC directly in the multiply, drive KDTC_EST=KDTC combinationally, and ignore PHE_SGN.

Verification
REQ-032 SHALL cover FCW_FRAC=16'h4000, KDTC=2048, EN rise: after PRIME, DTCDCW=512,1024,1536,0,512,... with CARRY=1 only on the 0 code, and VLD high from the 2nd RUN cycle.
REQ-033 SHALL cover FCW_FRAC=16'h0000, INIT_PHASE=16'h8000, KDTC=4095: constant DTCDCW=2047 and CARRY=0.
REQ-034 SHALL cover EN dropped mid-RUN for 1 cycle: VLD=0 and DTCDCW=0 that cycle, then the sequence restarts from INIT_PHASE.
REQ-035 SHALL cover RST asserted in RUN with EN=1: next edge all outputs 0, then PRIME and RUN follow RST release.
REQ-036 SHALL cover, with DTC_LMS_EN, KDTC=4094, LMS_STEP=1, PHE_SGN=1 held and FCW_FRAC=16'h9000: KDTC_EST climbs to 4095 and holds (saturation); with PHE_SGN=0 held from KDTC=1 it floors at 0.
REQ-037 SHALL cover, without DTC_LMS_EN, the same stimulus as REQ-036: KDTC_EST equals KDTC throughout.

Source files
------------

// File: rtl/dtc_ctrl.sv
// ---------------------------------------------------------------------------
// dtc_ctrl -- DTC control-word generator for a fractional-N PLL.
//
// A 16-bit phase accumulator integrates the fractional frequency control word
// once per reference cycle. The accumulator value (stage 1) is scaled by the
// DTC gain to form the DTC control word (stage 2). The accumulator carry-out
// travels with the word so the divider can swallow one CKV period in step
// with the DTC code it belongs to.
//
// Optional feature (macro DTC_LMS_EN):
//   undefined -> KDTC feeds the multiplier directly and PHE_SGN is ignored.
//   defined   -> a gain register starts at KDTC and is trimmed by +/-LMS_STEP
//                from the sign of the measured phase error.
//
// Parameters:
//   INIT_PHASE  accumulator value loaded when the FSM enters PRIME
//   LMS_STEP    gain trim step in LSBs (DTC_LMS_EN builds only)
//
// Ports:
//   CKR        in   reference clock, all logic on its rising edge
//   RST        in   synchronous active-high reset
//   EN         in   run enable; low forces IDLE
//   FCW_FRAC   in   [15:0] fractional FCW, units of 2^-16 CKV period
//   KDTC       in   [11:0] DTC gain, LSBs per full CKV period
//   PHE_SGN    in   phase error sign, 1 = late
//   DTCDCW     out  [11:0] DTC control word
//   CARRY      out  accumulator overflow aligned with DTCDCW
//   VLD        out  DTCDCW/CARRY valid
//   KDTC_EST   out  [11:0] gain actually applied
//   STATE_DBG  out  [1:0] FSM state (0 IDLE, 1 PRIME, 2 RUN)
// ---------------------------------------------------------------------------
module dtc_ctrl #(
    parameter logic [15:0] INIT_PHASE = 16'h0000,
    parameter int unsigned LMS_STEP   = 1
) (
    input  logic        CKR,
    input  logic        RST,
    input  logic        EN,
    input  logic [15:0] FCW_FRAC,
    input  logic [11:0] KDTC,
    input  logic        PHE_SGN,
    output logic [11:0] DTCDCW,
    output logic        CARRY,
    output logic        VLD,
    output logic [11:0] KDTC_EST,
    output logic [1:0]  STATE_DBG
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PRIME = 2'd1,
        S_RUN   = 2'd2
    } state_t;

    localparam logic [11:0] STEP = 12'(LMS_STEP);

    state_t      state_q;
    logic [15:0] acc_q;        // stage 1: accumulator
    logic        carry_s1_q;   // stage 1: carry-out of the update that made acc_q
    logic [11:0] dcw_q;        // stage 2
    logic        carry_q;      // stage 2
    logic        vld_q;

    logic [16:0] acc_sum;
    logic [11:0] gain;
    logic [27:0] prod;

    assign acc_sum = {1'b0, acc_q} + {1'b0, FCW_FRAC};
    // 16x12 unsigned product; the top 12 bits never exceed 4095.
    assign prod    = {12'd0, acc_q} * {16'd0, gain};

    // Single FSM block. EN low behaves like reset for the datapath, so VLD
    // and DTCDCW drop in the same cycle the state reads IDLE. The PRIME cycle
    // already accumulates, which places the first valid word on the second
    // RUN cycle with two cycles from an FCW_FRAC change to its DTCDCW.
    always_ff @(posedge CKR) begin
        if (RST || !EN) begin
            state_q    <= S_IDLE;
            acc_q      <= 16'd0;
            carry_s1_q <= 1'b0;
            dcw_q      <= 12'd0;
            carry_q    <= 1'b0;
            vld_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_q    <= S_PRIME;
                    acc_q      <= INIT_PHASE;
                    carry_s1_q <= 1'b0;
                end
                S_PRIME, S_RUN: begin
                    state_q    <= S_RUN;
                    acc_q      <= acc_sum[15:0];
                    carry_s1_q <= acc_sum[16];
                    dcw_q      <= prod[27:16];
                    carry_q    <= carry_s1_q;
                    vld_q      <= (state_q == S_RUN);
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

`ifdef DTC_LMS_EN
    logic [11:0] gain_q;
    logic [11:0] gain_d;

    // Saturating trim toward the phase-error sign.
    always_comb begin
        gain_d = gain_q;
        if (PHE_SGN) begin
            if (gain_q > (12'd4095 - STEP)) gain_d = 12'd4095;
            else                            gain_d = gain_q + STEP;
        end else begin
            if (gain_q < STEP) gain_d = 12'd0;
            else               gain_d = gain_q - STEP;
        end
    end

    // The gain follows KDTC while idle, so it holds KDTC on PRIME entry.
    // Trimming is only done in the upper half of the phase range.
    always_ff @(posedge CKR) begin
        if (RST || state_q == S_IDLE) begin
            gain_q <= KDTC;
        end else if (EN && state_q == S_RUN && vld_q && acc_q[15]) begin
            gain_q <= gain_d;
        end
    end

    assign gain     = gain_q;
    assign KDTC_EST = gain_q;
`else
    logic [12:0] unused_cfg;
    assign unused_cfg = {PHE_SGN, STEP};

    assign gain     = KDTC;
    assign KDTC_EST = KDTC;
`endif

    assign DTCDCW    = dcw_q;
    assign CARRY     = carry_q;
    assign VLD       = vld_q;
    assign STATE_DBG = state_q;

endmodule
